// File: rtl/fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// fp_add_scheduler : arbitrates two requesters onto one shared combinational
//                    FP adder and returns each result with its owner's id.
// Revision         : 1.0
// ============================================================================
module fp_add_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic             rsp_flag,
  output logic [31:0]      add_para1,
  output logic [31:0]      add_para2,
  input  logic [31:0]      add_out,
  input  logic             add_under_overflow,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] flag_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic             r_last_grant;
  logic [31:0]      r_para1;
  logic [31:0]      r_para2;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_flag;
  logic             r_rsp_valid;
  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_flag_cnt;

  logic             w_sel;
  logic             w_idle;
  logic             w_accept;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic             w_sub;

  // Under contention the port that did not win last time is granted.
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end
  end

  assign w_idle     = rst && (r_state == S_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_sel;
  assign req1_ready = w_idle && req1_valid && w_sel;
  assign w_accept   = req0_ready || req1_ready;
  assign w_a        = w_sel ? req1_a   : req0_a;
  assign w_b        = w_sel ? req1_b   : req0_b;
  assign w_sub      = w_sel ? req1_sub : req0_sub;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_para1      <= 32'd0;
      r_para2      <= 32'd0;
      r_rsp_data   <= 32'd0;
      r_rsp_id     <= 1'b0;
      r_rsp_flag   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_op_cnt     <= '0;
      r_flag_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_para1      <= w_a;
            // Subtraction is folded into the operand by flipping b's sign.
            r_para2      <= {w_b[31] ^ w_sub, w_b[30:0]};
            r_rsp_id     <= w_sel;
            r_last_grant <= w_sel;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= add_out;
          r_rsp_flag  <= add_under_overflow;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (r_op_cnt != c_CNT_MAX) begin
              r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
            if (r_rsp_flag && (r_flag_cnt != c_CNT_MAX)) begin
              r_flag_cnt <= r_flag_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_flag  = r_rsp_flag;
  assign add_para1 = r_para1;
  assign add_para2 = r_para2;
  assign op_cnt    = r_op_cnt;
  assign flag_cnt  = r_flag_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// tb_fp_add_scheduler : vector table plus scoreboard bench for fp_add_scheduler
// Revision            : 1.0
// ============================================================================
module tb_fp_add_scheduler;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic             req0_sub, req1_sub;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [31:0]      rsp_data;
  logic [31:0]      add_para1, add_para2, add_out;
  logic             add_under_overflow;
  logic [CNT_W-1:0] op_cnt, flag_cnt;
  logic             force_flag;

  fp_add_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .add_para1(add_para1), .add_para2(add_para2),
    .add_out(add_out), .add_under_overflow(add_under_overflow),
    .op_cnt(op_cnt), .flag_cnt(flag_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral single-precision adder (normal numbers, truncating).
  function automatic real f2r(input logic [31:0] x);
    if (x[30:23] == 8'd0) return 0.0;
    return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    real r;
    logic [63:0] d;
    r = f2r(x) + f2r(y);
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  assign add_out            = fadd(add_para1, add_para2);
  assign add_under_overflow = force_flag;

  typedef struct {
    logic        id;
    logic [31:0] p1, p2, data;
    logic        flag;
    int          cyc;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] exp_data, exp_p2;
    int          exp_cnt;
  } vec_t;

  exp_t        sb[$];
  int          grants[$];
  exp_t        e_mon, e_push;
  int          total, bad, cyc, hs;
  logic        prev_valid;
  logic [31:0] last_data;
  logic        last_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: push on accept, pop and compare on response.
  always @(negedge clk) begin
    chk("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
    if (rst) begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else                chk("latency", 64'(cyc), 64'(sb[0].cyc + 2));
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        e_mon = sb.pop_front();
        chk("rsp_id",    {63'd0, rsp_id},   {63'd0, e_mon.id});
        chk("rsp_data",  {32'd0, rsp_data}, {32'd0, e_mon.data});
        chk("rsp_flag",  {63'd0, rsp_flag}, {63'd0, e_mon.flag});
        chk("add_para1", {32'd0, add_para1}, {32'd0, e_mon.p1});
        chk("add_para2", {32'd0, add_para2}, {32'd0, e_mon.p2});
        last_data <= rsp_data;
        last_id   <= rsp_id;
        hs        <= hs + 1;
      end
      if (req0_valid && req0_ready) begin
        e_push.id   = 1'b0;
        e_push.p1   = req0_a;
        e_push.p2   = {req0_b[31] ^ req0_sub, req0_b[30:0]};
        e_push.data = fadd(e_push.p1, e_push.p2);
        e_push.flag = force_flag;
        e_push.cyc  = cyc;
        sb.push_back(e_push);
        grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        e_push.id   = 1'b1;
        e_push.p1   = req1_a;
        e_push.p2   = {req1_b[31] ^ req1_sub, req1_b[30:0]};
        e_push.data = fadd(e_push.p1, e_push.p2);
        e_push.flag = force_flag;
        e_push.cyc  = cyc;
        sb.push_back(e_push);
        grants.push_back(1);
      end
    end
    prev_valid <= rsp_valid;
  end

  task automatic drive(input int port, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = s;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = s;
    end
  endtask

  task automatic wait_accept(input int port);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (port == 0) ? req0_ready : req1_ready;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("accepted", {63'd0, got}, 64'd1);
  endtask

  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b, input logic s);
    int start;
    start = hs;
    drive(port, a, b, s);
    wait_accept(port);
    for (int n = 0; n < 20 && hs == start; n++) begin
      @(posedge clk); #1;
    end
    chk("rsp_done", {63'd0, (hs != start)}, 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    sb.delete();
    grants.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  vec_t        vecs[4];
  logic [31:0] h_data;
  logic        h_id, h_flag;

  initial begin
    vecs[0] = '{0, 32'h41480000, 32'h40A80000, 1'b0, 32'h418E0000, 32'h40A80000, 1};
    vecs[1] = '{1, 32'h41A20000, 32'h414C0000, 1'b1, 32'h40F00000, 32'hC14C0000, 2};
    vecs[2] = '{0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'hBF800000, 3};
    vecs[3] = '{1, 32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 32'hC0400000, 3};

    total = 0; bad = 0; hs = 0; prev_valid = 1'b0;
    last_data = 32'd0; last_id = 1'b0;
    rst = 1'b1; rsp_ready = 1'b1; force_flag = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_sub = 1'b0;

    // Asynchronous reset before any clock edge, with a requester tempting ready.
    #2 rst = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("rst_rsp_valid",  {63'd0, rsp_valid},  64'd0);
    chk("rst_rsp_data",   {32'd0, rsp_data},   64'd0);
    chk("rst_para1",      {32'd0, add_para1},  64'd0);
    chk("rst_para2",      {32'd0, add_para2},  64'd0);
    chk("rst_op_cnt",     64'(op_cnt),         64'd0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sub);
      chk("vec_data",   {32'd0, last_data}, {32'd0, vecs[i].exp_data});
      chk("vec_id",     {63'd0, last_id},   64'(vecs[i].port));
      chk("vec_para2",  {32'd0, add_para2}, {32'd0, vecs[i].exp_p2});
      chk("vec_op_cnt", 64'(op_cnt),        64'(vecs[i].exp_cnt));
      chk("vec_flag_cnt", 64'(flag_cnt),    64'd0);
    end

    // Contention straight out of reset: port0 first, then strict alternation.
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    sb.delete();
    grants.delete();
    drive(0, 32'h41480000, 32'h40A80000, 1'b0);
    drive(1, 32'h41A20000, 32'h414C0000, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("first_ready0", {63'd0, req0_ready}, 64'd1);
    chk("first_ready1", {63'd0, req1_ready}, 64'd0);
    for (int n = 0; n < 40 && grants.size() < 4; n++) begin
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("grant_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("grant_order", 64'(grants[i]), 64'(i % 2));
    for (int n = 0; n < 10 && sb.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    chk("contention_drained", 64'(sb.size()), 64'd0);

    // Consumer back-pressure: response held stable, no accepts, no count.
    do_reset();
    rsp_ready = 1'b0;
    drive(0, 32'h3FC00000, 32'h40100000, 1'b0);
    wait_accept(0);
    drive(1, 32'h41A20000, 32'h414C0000, 1'b1);
    for (int n = 0; n < 10 && !rsp_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
    chk("hold_data0", {32'd0, rsp_data}, 64'h40700000);
    h_data = rsp_data; h_id = rsp_id; h_flag = rsp_flag;
    repeat (5) begin
      @(negedge clk);
      chk("hold_stable", {rsp_valid, rsp_id, rsp_flag, rsp_data}, {1'b1, h_id, h_flag, h_data});
      chk("hold_readys", {62'd0, req0_ready, req1_ready}, 64'd0);
      chk("hold_op_cnt", 64'(op_cnt), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("hold_done_cnt",   64'(op_cnt), 64'd1);
    chk("hold_done_valid", {63'd0, rsp_valid}, 64'd0);

    // Reset pulse while the adder result is being captured.
    drive(0, 32'h41480000, 32'h40A80000, 1'b0);
    wait_accept(0);
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", {rsp_valid, rsp_id, rsp_flag, rsp_data, req0_ready, req1_ready},
        {1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0});
    chk("abort_paras",  {add_para1, add_para2}, 64'd0);
    chk("abort_op_cnt", 64'(op_cnt), 64'd0);
    sb.delete();
    grants.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    chk("abort_op_cnt_after", 64'(op_cnt), 64'd0);

    // Counter saturation with every result flagged.
    do_reset();
    force_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(i % 2, vecs[i % 2].a, vecs[i % 2].b, vecs[i % 2].sub);
      chk("sat_op_cnt",   64'(op_cnt),   64'((i < 3) ? i + 1 : 3));
      chk("sat_flag_cnt", 64'(flag_cnt), 64'((i < 3) ? i + 1 : 3));
    end
    force_flag = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
